// File: rtl/net_load_sequencer_pkg.sv
// net_load_sequencer_pkg
// Shared definitions for the network load sequencer:
//   - network shape (input / hidden / output node counts)
//   - layer tag constants carried with every weight word
//   - sequencer FSM state encoding
//   - helper that sizes a layer's weight block (fan-in weights plus one bias per node)
package net_load_sequencer_pkg;

  localparam int NET_INPUT_NODES  = 2;
  localparam int NET_HIDDEN_1     = 32;
  localparam int NET_HIDDEN_2     = 32;
  localparam int NET_OUTPUT_NODES = 3;

  localparam int LAYER_TAG_1 = 1;
  localparam int LAYER_TAG_2 = 2;
  localparam int LAYER_TAG_3 = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WEIGHT = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DATA   = 3'd3,
    ST_WAIT_Q = 3'd4
  } seq_state_t;

  // Each node stores fan_in weights followed by its bias.
  function automatic int layer_words(input int fan_in, input int nodes);
    return nodes * (fan_in + 1);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2
// Two-entry synchronous FIFO holding tagged weight words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write strobe and word
//   pop         : remove the head word
//   head        : current head word (valid when !empty)
//   empty       : no word stored
//   count       : number of stored words (0..2)
module sync_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/net_load_sequencer.sv
// net_load_sequencer
// Streams the weights of a 3-layer network from a read-latency-1 RAM to a
// ready/valid weight port, then presents the input vector one word per
// cycle, then waits for the network result and captures it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_start, i_skip_weights, i_state : start request, skip weight phase, input vector
//   o_mem_ren/rlayer/raddr, i_mem_rdata : weight RAM read port
//   o_weight_valid, i_weight_ready, o_weight_layer/addr, o_weight : weight stream
//   o_load_weight_done    : pulse once the last weight has been accepted
//   o_data_valid, o_data_addr, o_data : input data stream (no backpressure)
//   i_q_max_valid, i_q_max : network result
//   o_q_max, o_done       : captured result and its update pulse
//   o_busy                : sequencer not idle
module net_load_sequencer
  import net_load_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = NET_INPUT_NODES,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = NET_HIDDEN_1,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = NET_HIDDEN_2,
  parameter int NUMBER_OF_OUTPUT_NODE         = NET_OUTPUT_NODES,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int DATA_COUNTER_WIDTH            = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_start,
  input  logic                                       i_skip_weights,
  input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_state,
  output logic                                       o_mem_ren,
  output logic [LAYER_WIDTH-1:0]                     o_mem_rlayer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_mem_raddr,
  input  logic [DATA_WIDTH-1:0]                      i_mem_rdata,
  output logic                                       o_weight_valid,
  input  logic                                       i_weight_ready,
  output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_weight_addr,
  output logic [DATA_WIDTH-1:0]                      o_weight,
  output logic                                       o_load_weight_done,
  output logic                                       o_data_valid,
  output logic [DATA_COUNTER_WIDTH-1:0]              o_data_addr,
  output logic [DATA_WIDTH-1:0]                      o_data,
  input  logic                                       i_q_max_valid,
  input  logic [DATA_WIDTH-1:0]                      i_q_max,
  output logic [DATA_WIDTH-1:0]                      o_q_max,
  output logic                                       o_done,
  output logic                                       o_busy
);

  localparam int LW  = LAYER_WIDTH;
  localparam int WCW = WEIGHT_COUNTER_WIDTH;
  localparam int DCW = DATA_COUNTER_WIDTH;
  localparam int ENTRY_W = LW + WCW + DATA_WIDTH;

  localparam logic [LW-1:0] TAG_1 = LW'(LAYER_TAG_1);
  localparam logic [LW-1:0] TAG_2 = LW'(LAYER_TAG_2);
  localparam logic [LW-1:0] TAG_3 = LW'(LAYER_TAG_3);

  localparam logic [WCW-1:0] L1_LAST =
    WCW'(layer_words(NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1) - 1);
  localparam logic [WCW-1:0] L2_LAST =
    WCW'(layer_words(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2) - 1);
  localparam logic [WCW-1:0] L3_LAST =
    WCW'(layer_words(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE) - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(NUMBER_OF_INPUT_NODE - 1);

  seq_state_t state, state_next;

  // Read-side counters: the node/index walk n*(fan_in+1)+w is simply a
  // linear address sweep over each layer block.
  logic [LW-1:0]  rd_layer;
  logic [WCW-1:0] rd_addr;
  logic           rd_last_word;

  // Tag of the read whose data returns next cycle.
  logic           in_flight;
  logic [LW-1:0]  flight_layer;
  logic [WCW-1:0] flight_addr;

  logic [DCW-1:0]                             data_cnt;
  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] state_vec;
  logic [DATA_WIDTH-1:0]                      data_word;

  logic               mem_ren, load_done, data_valid, data_last, q_take;
  logic [2:0]         occupancy;
  logic               fifo_push, fifo_pop, fifo_empty;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] arrive_entry, fifo_head, head_entry;
  logic               weight_valid;

  always_comb begin
    rd_last_word = 1'b0;
    if (rd_layer == TAG_1)      rd_last_word = (rd_addr == L1_LAST);
    else if (rd_layer == TAG_2) rd_last_word = (rd_addr == L2_LAST);
    else if (rd_layer == TAG_3) rd_last_word = (rd_addr == L3_LAST);
  end

  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (i_start) state_next = i_skip_weights ? ST_DATA : ST_WEIGHT;
      ST_WEIGHT: if (mem_ren && rd_last_word && (rd_layer == TAG_3)) state_next = ST_DRAIN;
      ST_DRAIN:  if (load_done) state_next = ST_DATA;
      ST_DATA:   if (data_last) state_next = ST_WAIT_Q;
      ST_WAIT_Q: if (i_q_max_valid) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_ren    = 1'b0;
    load_done  = 1'b0;
    data_valid = 1'b0;
    q_take     = 1'b0;
    unique case (state)
      ST_WEIGHT: mem_ren    = (occupancy < 3'd2);
      ST_DRAIN:  load_done  = fifo_empty && !in_flight;
      ST_DATA:   data_valid = 1'b1;
      ST_WAIT_Q: q_take     = i_q_max_valid;
      default:   ;
    endcase
  end

  assign data_last = data_valid && (data_cnt == DATA_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_layer  <= '0;
      rd_addr   <= '0;
      in_flight <= 1'b0;
      data_cnt  <= '0;
      o_q_max   <= '0;
      o_done    <= 1'b0;
    end else begin
      in_flight <= mem_ren;
      if ((state == ST_IDLE) && i_start) begin
        rd_layer <= i_skip_weights ? '0 : TAG_1;
        rd_addr  <= '0;
      end else if (mem_ren) begin
        if (rd_last_word) begin
          rd_addr  <= '0;
          rd_layer <= (rd_layer == TAG_3) ? '0 : rd_layer + LW'(1);
        end else begin
          rd_addr <= rd_addr + WCW'(1);
        end
      end
      if (data_valid) data_cnt <= data_last ? '0 : data_cnt + DCW'(1);
      o_done <= q_take;
      if (q_take) o_q_max <= i_q_max;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_ren) begin
      flight_layer <= rd_layer;
      flight_addr  <= rd_addr;
    end
    if ((state == ST_IDLE) && i_start) state_vec <= i_state;
  end

  // Returning data bypasses an empty FIFO so the first word is presented
  // the cycle it arrives; if not accepted it is pushed and becomes the head,
  // which keeps the presented word stable across the stall.
  assign arrive_entry = {flight_layer, flight_addr, i_mem_rdata};
  assign fifo_push    = in_flight && !(fifo_empty && i_weight_ready);
  assign fifo_pop     = !fifo_empty && i_weight_ready;
  assign head_entry   = fifo_empty ? arrive_entry : fifo_head;
  assign weight_valid = !fifo_empty || in_flight;

  sync_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (arrive_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    data_word = '0;
    for (int i = 0; i < NUMBER_OF_INPUT_NODE; i++) begin
      if (data_cnt == DCW'(i)) data_word = state_vec[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_mem_ren          = mem_ren;
  assign o_mem_rlayer       = rd_layer;
  assign o_mem_raddr        = rd_addr;
  assign o_weight_valid     = weight_valid;
  assign o_weight_layer     = weight_valid ? head_entry[ENTRY_W-1 -: LW] : '0;
  assign o_weight_addr      = weight_valid ? head_entry[DATA_WIDTH +: WCW] : '0;
  assign o_weight           = weight_valid ? head_entry[DATA_WIDTH-1:0] : '0;
  assign o_load_weight_done = load_done;
  assign o_data_valid       = data_valid;
  assign o_data_addr        = data_valid ? data_cnt : '0;
  assign o_data             = data_valid ? data_word : '0;
  assign o_busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_net_load_sequencer.sv
module tb_net_load_sequencer;

  localparam int DW  = 32;
  localparam int LW  = 2;
  localparam int WCW = 11;
  localparam int DCW = 5;
  localparam int NIN = 2;
  localparam int TOTAL_WORDS = 1251;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_skip_weights = 1'b0;
  logic [NIN*DW-1:0]  i_state = '0;
  logic               o_mem_ren;
  logic [LW-1:0]      o_mem_rlayer;
  logic [WCW-1:0]     o_mem_raddr;
  logic [DW-1:0]      i_mem_rdata = '0;
  logic               o_weight_valid;
  logic               i_weight_ready = 1'b1;
  logic [LW-1:0]      o_weight_layer;
  logic [WCW-1:0]     o_weight_addr;
  logic [DW-1:0]      o_weight;
  logic               o_load_weight_done;
  logic               o_data_valid;
  logic [DCW-1:0]     o_data_addr;
  logic [DW-1:0]      o_data;
  logic               i_q_max_valid = 1'b0;
  logic [DW-1:0]      i_q_max = '0;
  logic [DW-1:0]      o_q_max;
  logic               o_done;
  logic               o_busy;

  net_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_skip_weights(i_skip_weights),
    .i_state(i_state), .o_mem_ren(o_mem_ren), .o_mem_rlayer(o_mem_rlayer),
    .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata), .o_weight_valid(o_weight_valid),
    .i_weight_ready(i_weight_ready), .o_weight_layer(o_weight_layer),
    .o_weight_addr(o_weight_addr), .o_weight(o_weight), .o_load_weight_done(o_load_weight_done),
    .o_data_valid(o_data_valid), .o_data_addr(o_data_addr), .o_data(o_data),
    .i_q_max_valid(i_q_max_valid), .i_q_max(i_q_max), .o_q_max(o_q_max),
    .o_done(o_done), .o_busy(o_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int layer; int addr; logic [DW-1:0] data; } wexp_t;
  typedef struct { int addr; logic [DW-1:0] data; } dexp_t;
  typedef struct { logic [DW-1:0] q; int cyc; } qexp_t;

  wexp_t exp_w[$];
  dexp_t exp_d[$];
  qexp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW-1:0] salt = '0;
  logic [DW-1:0] last_q = '0;
  bit rand_ready = 1'b0;

  // per-run trackers, written by the monitor
  int xfers, ren_cnt, wv_cnt, ld_cnt, ld_cyc, first_v_cyc, last_xfer_cyc;
  int data_seen, first_data_cyc, last_data_cyc, done_seen;
  bit prev_stall = 1'b0;
  logic [LW-1:0]  prev_layer;
  logic [WCW-1:0] prev_addr;
  logic [DW-1:0]  prev_data;

  int fan_in[3] = '{2, 32, 32};
  int nodes[3]  = '{32, 32, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=missing required=event", name);
  endtask

  // Weight RAM contents: a salted function of layer and address.
  function automatic logic [DW-1:0] ram_word(input int layer, input int addr);
    return salt ^ (32'(layer) << 28) ^ (32'(addr) * 32'h9E3779B1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (o_mem_ren) i_mem_rdata <= ram_word(int'(o_mem_rlayer), int'(o_mem_raddr));
    else           i_mem_rdata <= $urandom;
  end

  initial forever begin
    @(posedge clk);
    #1;
    i_weight_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (o_mem_ren) ren_cnt++;
      if (o_weight_valid) wv_cnt++;
      if (o_weight_valid) begin
        if (first_v_cyc < 0) first_v_cyc = cyc;
        if (prev_stall) begin
          chk("stall_layer", 64'(o_weight_layer), 64'(prev_layer));
          chk("stall_addr", 64'(o_weight_addr), 64'(prev_addr));
          chk("stall_data", 64'(o_weight), 64'(prev_data));
        end
        if (i_weight_ready) begin
          if (exp_w.size() == 0) begin
            flag("weight_unexpected");
          end else begin
            wexp_t e;
            e = exp_w.pop_front();
            chk("w_layer", 64'(o_weight_layer), 64'(e.layer));
            chk("w_addr", 64'(o_weight_addr), 64'(e.addr));
            chk("w_data", 64'(o_weight), 64'(e.data));
          end
          xfers++;
          last_xfer_cyc = cyc;
        end
      end else if (prev_stall) begin
        flag("valid_dropped_in_stall");
      end
      prev_stall = o_weight_valid && !i_weight_ready;
      prev_layer = o_weight_layer;
      prev_addr  = o_weight_addr;
      prev_data  = o_weight;

      if (o_load_weight_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end

      if (o_data_valid) begin
        if (exp_d.size() == 0) begin
          flag("data_unexpected");
        end else begin
          dexp_t d;
          d = exp_d.pop_front();
          chk("d_addr", 64'(o_data_addr), 64'(d.addr));
          chk("d_data", 64'(o_data), 64'(d.data));
        end
        if (data_seen == 0) first_data_cyc = cyc;
        last_data_cyc = cyc;
        data_seen++;
      end

      if (o_done) begin
        if (exp_q.size() == 0) begin
          flag("done_unexpected");
        end else begin
          qexp_t q;
          q = exp_q.pop_front();
          chk("q_max", 64'(o_q_max), 64'(q.q));
          chk("done_latency", 64'(cyc - q.cyc), 64'd1);
        end
        done_seen++;
      end
    end
  end

  task automatic clear_trackers();
    xfers = 0; ren_cnt = 0; wv_cnt = 0; ld_cnt = 0; ld_cyc = -1;
    first_v_cyc = -1; last_xfer_cyc = -1; data_seen = 0;
    first_data_cyc = -1; last_data_cyc = -1; done_seen = 0;
  endtask

  // Reference weight order: layer by layer, node by node, weights then bias.
  task automatic push_weights();
    for (int l = 0; l < 3; l++)
      for (int n = 0; n < nodes[l]; n++)
        for (int w = 0; w <= fan_in[l]; w++) begin
          wexp_t e;
          e.layer = l + 1;
          e.addr  = n * (fan_in[l] + 1) + w;
          e.data  = ram_word(e.layer, e.addr);
          exp_w.push_back(e);
        end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_ren"}, 64'(o_mem_ren), 64'd0);
    chk({tag, "_rlayer"}, 64'(o_mem_rlayer), 64'd0);
    chk({tag, "_raddr"}, 64'(o_mem_raddr), 64'd0);
    chk({tag, "_wvalid"}, 64'(o_weight_valid), 64'd0);
    chk({tag, "_wlayer"}, 64'(o_weight_layer), 64'd0);
    chk({tag, "_waddr"}, 64'(o_weight_addr), 64'd0);
    chk({tag, "_weight"}, 64'(o_weight), 64'd0);
    chk({tag, "_lddone"}, 64'(o_load_weight_done), 64'd0);
    chk({tag, "_dvalid"}, 64'(o_data_valid), 64'd0);
    chk({tag, "_data"}, 64'(o_data), 64'd0);
    chk({tag, "_qmax"}, 64'(o_q_max), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
  endtask

  task automatic issue_start(input bit skip, input logic [NIN*DW-1:0] st, output int start_cyc);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_skip_weights = skip;
    i_state = st;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_skip_weights = 1'($urandom_range(0, 1));
    i_state = {$urandom, $urandom};
  endtask

  task automatic run_seq(input bit skip, input bit rnd, input logic [NIN*DW-1:0] st,
                         input logic [DW-1:0] qv, input bit poke);
    int start_cyc;
    int guard;
    qexp_t qe;
    clear_trackers();
    salt = $urandom;
    rand_ready = rnd;
    if (!skip) push_weights();
    for (int i = 0; i < NIN; i++) begin
      dexp_t d;
      d.addr = i;
      d.data = st[i*DW +: DW];
      exp_d.push_back(d);
    end
    issue_start(skip, st, start_cyc);

    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      i_q_max_valid = 1'b1;
      i_q_max = $urandom;
      i_start = 1'b1;
      i_skip_weights = 1'b1;
      @(posedge clk);
      #1;
      i_q_max_valid = 1'b0;
      i_start = 1'b0;
      @(negedge clk);
      chk("q_ignored_in_weight", 64'(o_q_max), 64'(last_q));
      chk("busy_in_weight", 64'(o_busy), 64'd1);
    end

    guard = 0;
    while (data_seen < NIN && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (data_seen < NIN) flag("data_timeout");

    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    i_q_max_valid = 1'b1;
    i_q_max = qv;
    qe.q = qv;
    qe.cyc = cyc;
    exp_q.push_back(qe);
    @(posedge clk);
    #1;
    i_q_max_valid = 1'b0;
    i_q_max = $urandom;

    guard = 0;
    while (done_seen < 1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (done_seen < 1) flag("done_timeout");
    last_q = qv;
    chk("busy_after_done", 64'(o_busy), 64'd0);
    chk("done_count", 64'(done_seen), 64'd1);
    chk("data_consecutive", 64'(last_data_cyc - first_data_cyc), 64'(NIN - 1));
    if (!skip) begin
      chk("xfer_count", 64'(xfers), 64'(TOTAL_WORDS));
      chk("weights_left", 64'(exp_w.size()), 64'd0);
      chk("first_valid_latency", 64'(first_v_cyc - start_cyc), 64'd2);
      chk("ld_done_count", 64'(ld_cnt), 64'd1);
      chk("ld_done_latency", 64'(ld_cyc - last_xfer_cyc), 64'd1);
      chk("data_after_ld", 64'(first_data_cyc - ld_cyc), 64'd1);
      if (!rnd) chk("no_gaps", 64'(last_xfer_cyc - first_v_cyc), 64'(TOTAL_WORDS - 1));
    end else begin
      chk("skip_ren", 64'(ren_cnt), 64'd0);
      chk("skip_wvalid", 64'(wv_cnt), 64'd0);
      chk("skip_ld_done", 64'(ld_cnt), 64'd0);
      chk("skip_data_latency", 64'(first_data_cyc - start_cyc), 64'd1);
    end
    rand_ready = 1'b0;
  endtask

  task automatic run_abort();
    int start_cyc;
    int guard;
    clear_trackers();
    salt = $urandom;
    rand_ready = 1'b0;
    push_weights();
    issue_start(1'b0, {$urandom, $urandom}, start_cyc);
    guard = 0;
    while (xfers < 500 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (xfers < 500) flag("abort_timeout");
    chk("xfers_at_abort", 64'(xfers), 64'd500);
    #1;
    rst_n = 1'b0;
    exp_w.delete();
    exp_d.delete();
    exp_q.delete();
    last_q = '0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_trackers();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_seq(1'b0, 1'b0, {32'h3FA00000, 32'hBFC00000}, 32'h40490FDB, 1'b1);
    run_seq(1'b0, 1'b1, {$urandom, $urandom}, $urandom, 1'b1);
    run_seq(1'b1, 1'b0, {32'h3FA00000, 32'hBFC00000}, $urandom, 1'b0);
    run_abort();
    run_seq(1'b0, 1'b0, {$urandom, $urandom}, $urandom, 1'b0);
    run_seq(1'b1, 1'b1, {$urandom, $urandom}, $urandom, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
